// File: rtl/video_timing_controller_if.sv
// Timing-configuration port of the video timing controller: field writes, commit request, busy/error status.
interface video_timing_controller_if #(
    parameter int DATA_BITS = 10
);
    logic                 cfg_wr;
    logic [2:0]           cfg_sel;
    logic [DATA_BITS-1:0] cfg_data;
    logic                 cfg_commit;
    logic                 cfg_busy;
    logic                 cfg_err;

    modport master (
        output cfg_wr, cfg_sel, cfg_data, cfg_commit,
        input  cfg_busy, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_sel, cfg_data, cfg_commit,
        output cfg_busy, cfg_err
    );
endinterface

// File: rtl/video_timing_controller.sv
// Pixel/line timing for the Pong video path: x/y counters, sync/active decode, frame-safe reprogramming.
// Latency: every output is registered and aligned with xposition/yposition; VTC_FRAMECOUNT_EN adds frame_count.
// Backpressure: none; writes while a commit is pending are dropped and flagged on cfg_err.
module video_timing_controller #(
    parameter int XRES_BITS = 10,
    parameter int YRES_BITS = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pixel_en,
    input  logic                     run,
    video_timing_controller_if.slave cfg,
    output logic                     hsync,
    output logic                     vsync,
    output logic                     active_video,
    output logic                     line_end,
    output logic                     frame_end,
    output logic [XRES_BITS-1:0]     xposition,
    output logic [YRES_BITS-1:0]     yposition
`ifdef VTC_FRAMECOUNT_EN
    ,
    output logic [15:0]              frame_count
`endif
);
    localparam int XT = XRES_BITS + 2;
    localparam int YT = YRES_BITS + 2;

    typedef struct packed {
        logic [XRES_BITS-1:0] ha;
        logic [XRES_BITS-1:0] hfp;
        logic [XRES_BITS-1:0] hs;
        logic [XRES_BITS-1:0] hbp;
        logic [YRES_BITS-1:0] va;
        logic [YRES_BITS-1:0] vfp;
        logic [YRES_BITS-1:0] vs;
        logic [YRES_BITS-1:0] vbp;
    } timing_t;

    localparam timing_t TIMING_RST = {
        XRES_BITS'(H_ACTIVE), XRES_BITS'(H_FP), XRES_BITS'(H_SYNC), XRES_BITS'(H_BP),
        YRES_BITS'(V_ACTIVE), YRES_BITS'(V_FP), YRES_BITS'(V_SYNC), YRES_BITS'(V_BP)
    };

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t  state;
    timing_t pend;
    timing_t pend_nxt;
    timing_t shadow;
    logic    busy;
    logic    err;

    logic [XT-1:0] p_ht;
    logic [YT-1:0] p_vt;
    logic [XT-1:0] s_ht;
    logic [YT-1:0] s_vt;
    logic [XT-1:0] s_hs_beg;
    logic [XT-1:0] s_hs_end;
    logic [YT-1:0] s_vs_beg;
    logic [YT-1:0] s_vs_end;

    logic                 commit_ok;
    logic                 x_last;
    logic                 y_last;
    logic                 frame_wrap;
    logic                 apply;
    logic [XRES_BITS-1:0] x_nxt;
    logic [YRES_BITS-1:0] y_nxt;
    logic                 x_nxt_last;
    logic                 y_nxt_last;
    logic                 in_hs;
    logic                 in_vs;

    assign cfg.cfg_busy = busy;
    assign cfg.cfg_err  = err;

    // A same-cycle write lands before the commit is validated, so validation runs on pend_nxt.
    always_comb begin
        pend_nxt = pend;
        if (cfg.cfg_wr && !busy) begin
            case (cfg.cfg_sel)
                3'd0: pend_nxt.ha  = cfg.cfg_data[XRES_BITS-1:0];
                3'd1: pend_nxt.hfp = cfg.cfg_data[XRES_BITS-1:0];
                3'd2: pend_nxt.hs  = cfg.cfg_data[XRES_BITS-1:0];
                3'd3: pend_nxt.hbp = cfg.cfg_data[XRES_BITS-1:0];
                3'd4: pend_nxt.va  = cfg.cfg_data[YRES_BITS-1:0];
                3'd5: pend_nxt.vfp = cfg.cfg_data[YRES_BITS-1:0];
                3'd6: pend_nxt.vs  = cfg.cfg_data[YRES_BITS-1:0];
                default: pend_nxt.vbp = cfg.cfg_data[YRES_BITS-1:0];
            endcase
        end
    end

    assign p_ht = XT'(pend_nxt.ha) + XT'(pend_nxt.hfp) + XT'(pend_nxt.hs) + XT'(pend_nxt.hbp);
    assign p_vt = YT'(pend_nxt.va) + YT'(pend_nxt.vfp) + YT'(pend_nxt.vs) + YT'(pend_nxt.vbp);

    assign commit_ok = (pend_nxt.ha != '0) && (pend_nxt.hs != '0) &&
                       (pend_nxt.va != '0) && (pend_nxt.vs != '0) &&
                       (p_ht <= XT'({XRES_BITS{1'b1}})) && (p_vt <= YT'({YRES_BITS{1'b1}}));

    assign s_ht     = XT'(shadow.ha) + XT'(shadow.hfp) + XT'(shadow.hs) + XT'(shadow.hbp);
    assign s_vt     = YT'(shadow.va) + YT'(shadow.vfp) + YT'(shadow.vs) + YT'(shadow.vbp);
    assign s_hs_beg = XT'(shadow.ha) + XT'(shadow.hfp);
    assign s_hs_end = s_hs_beg + XT'(shadow.hs) - XT'(1);
    assign s_vs_beg = YT'(shadow.va) + YT'(shadow.vfp);
    assign s_vs_end = s_vs_beg + YT'(shadow.vs) - YT'(1);

    assign x_last     = (XT'(xposition) == s_ht - XT'(1));
    assign y_last     = (YT'(yposition) == s_vt - YT'(1));
    assign frame_wrap = run && pixel_en && x_last && y_last;
    assign apply      = (state == ARMED) && (!run || frame_wrap);

    always_comb begin
        x_nxt = xposition;
        y_nxt = yposition;
        if (!run) begin
            x_nxt = '0;
            y_nxt = '0;
        end else if (pixel_en) begin
            if (x_last) begin
                x_nxt = '0;
                y_nxt = y_last ? '0 : yposition + 1'b1;
            end else begin
                x_nxt = xposition + 1'b1;
            end
        end
    end

    // Decoding with the pre-apply shadow is safe: an apply always lands on (0,0), whose decode is timing-independent.
    assign x_nxt_last = (XT'(x_nxt) == s_ht - XT'(1));
    assign y_nxt_last = (YT'(y_nxt) == s_vt - YT'(1));
    assign in_hs      = (XT'(x_nxt) >= s_hs_beg) && (XT'(x_nxt) <= s_hs_end);
    assign in_vs      = (YT'(y_nxt) >= s_vs_beg) && (YT'(y_nxt) <= s_vs_end);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xposition    <= '0;
            yposition    <= '0;
            hsync        <= 1'b1;
            vsync        <= 1'b1;
            active_video <= 1'b0;
            line_end     <= 1'b0;
            frame_end    <= 1'b0;
        end else begin
            xposition <= x_nxt;
            yposition <= y_nxt;
            if (!run) begin
                hsync        <= 1'b1;
                vsync        <= 1'b1;
                active_video <= 1'b0;
                line_end     <= 1'b0;
                frame_end    <= 1'b0;
            end else begin
                hsync        <= !in_hs;
                vsync        <= !in_vs;
                active_video <= (XT'(x_nxt) < XT'(shadow.ha)) && (YT'(y_nxt) < YT'(shadow.va));
                line_end     <= pixel_en && x_nxt_last;
                frame_end    <= pixel_en && x_nxt_last && y_nxt_last;
            end
        end
    end

    // Pending fields are frozen while ARMED (writes rejected), so the copy sees exactly the validated set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pend   <= TIMING_RST;
            shadow <= TIMING_RST;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            pend <= pend_nxt;
            err  <= (cfg.cfg_wr && busy) || (cfg.cfg_commit && !busy && !commit_ok);
            case (state)
                IDLE: begin
                    if (cfg.cfg_commit && commit_ok) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (apply) begin
                        shadow <= pend;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VTC_FRAMECOUNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_count <= '0;
        end else if (apply) begin
            frame_count <= '0;
        end else if (run && pixel_en && x_nxt_last && y_nxt_last) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/video_timing_controller.md
Name: video_timing_controller

Overview:
- Sequences the horizontal and vertical pixel counters for the Pong video path.
- Generates hsync, vsync, active-video, line-end and frame-end strobes, plus x/y coordinates consumed by the ball, paddle and score renderers.
- Holds programmable porch, sync and active timing in pending registers. These are committed atomically to shadow registers only at a frame boundary, so timing never changes mid-frame.

Parameters:
- XRES_BITS, 10, width of horizontal timing fields and xposition
- YRES_BITS, 10, width of vertical timing fields and yposition
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, reset horizontal timing
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, reset vertical timing

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pixel_en  in  1  pixel-rate clock enable; all counting happens only on cycles where pixel_en=1
- run  in  1  1 = counters run; 0 = counters held at 0
- cfg_wr  in  1  write strobe for a pending timing field
- cfg_sel  in  3  field select: 0 HA, 1 HFP, 2 HS, 3 HBP, 4 VA, 5 VFP, 6 VS, 7 VBP
- cfg_data  in  max(XRES_BITS,YRES_BITS)  field value; low bits are used for H fields
- cfg_commit  in  1  request to apply the pending fields at the next frame end
- cfg_busy  out  1  commit accepted but not yet applied
- cfg_err  out  1  one-cycle pulse: rejected write or rejected commit
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- active_video  out  1  1 inside the visible region
- line_end  out  1  one pixel_en-cycle pulse on the last pixel of each line
- frame_end  out  1  one pixel_en-cycle pulse on the last pixel of the frame
- xposition  out  XRES_BITS  horizontal counter
- yposition  out  YRES_BITS  vertical counter

Behaviour:
- Reset state:
  - Pending and shadow registers load the parameter defaults.
  - xposition=0, yposition=0.
  - hsync=1, vsync=1.
  - active_video=0, line_end=0, frame_end=0, cfg_busy=0, cfg_err=0.
- Line order is Active, FrontPorch, Sync, BackPorch.
  - HT = HA+HFP+HS+HBP; VT likewise. Totals are computed at width+2 bits.
- Horizontal counter (pixel_en=1 and run=1):
  - xposition increments each cycle.
  - At HT-1 it wraps to 0 and yposition increments.
  - When xposition wraps with yposition=VT-1, yposition also wraps to 0.
- Decode (all outputs registered and aligned with the current xposition/yposition):
  - hsync=0 iff HA+HFP ≤ x ≤ HA+HFP+HS-1.
  - vsync=0 iff VA+VFP ≤ y ≤ VA+VFP+VS-1.
  - active_video = (x<HA)&&(y<VA).
  - line_end=1 while x=HT-1.
  - frame_end=1 while x=HT-1 and y=VT-1.
  - line_end and frame_end are qualified by pixel_en, so each lasts exactly one clock.
- run=0:
  - x and y are forced to 0 on the next clock.
  - hsync=vsync=1, active_video=0, no strobes.
  - Counting resumes from (0,0) when run returns to 1.
- Config write:
  - cfg_wr with cfg_busy=0 stores cfg_data into the selected pending field.
  - cfg_wr with cfg_busy=1 is ignored and cfg_err pulses.
- Commit:
  - cfg_commit is validated on the pending set.
  - Rejected (cfg_err pulses, busy stays 0) if HA, HS, VA or VS is 0, if HT > 2^XRES_BITS-1, or if VT > 2^YRES_BITS-1.
  - Otherwise cfg_busy=1.
  - cfg_commit while cfg_busy=1 is ignored, with no error.
- Apply state machine, states IDLE → ARMED → IDLE:
  - In ARMED, on the clock where frame_end fires, the shadow registers copy the pending fields and cfg_busy clears the next cycle.
  - If run=0 while ARMED, the copy happens immediately on the next clock.
  - The new timing takes effect from pixel (0,0) of the next frame.
- Simultaneous events: if cfg_wr and cfg_commit occur in the same cycle, the write lands first and the commit validates the updated pending set.
- Reset mid-operation aborts any pending commit and restores the defaults.

Optional Feature:
- Macro VTC_FRAMECOUNT_EN.
- Defined: adds output frame_count[15:0].
  - Reset value 0.
  - Increments on every frame_end and wraps 0xFFFF→0.
  - Clears on a committed timing apply.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, run=1, pixel_en every cycle, defaults:
  - line_end every 800 cycles; frame_end every 420000 cycles.
  - hsync low for x=656..751; vsync low for y=490..491.
  - active_video high for 640 cycles on lines 0..479.
- pixel_en every 2nd cycle:
  - xposition steps every 2 clocks.
  - line_end is exactly 1 clock wide, every 1600 clocks.
- Write HA=320, HFP=8, HS=48, HBP=24 and commit at y=100:
  - cfg_busy=1 until frame_end, and the current frame keeps HT=800.
  - The next frame has HT=400 with hsync low at x=328..375.
- Commit with HS=0, or cfg_wr while busy:
  - One-cycle cfg_err; timing unchanged; busy state unaffected.
- run dropped to 0 at (x=300, y=200):
  - Next clock x=y=0, hsync=vsync=1.
  - run=1 restarts from (0,0).
- Reset asserted mid-frame with a commit ARMED:
  - All outputs return to reset values and defaults are restored.
  - With VTC_FRAMECOUNT_EN defined, frame_count=0 and it increments to 1 after the first frame_end.
